// File: rtl/addsub_arbiter_if.sv
// Bus between the two requesters, the shared complementer/adder datapath
// and the addsub_arbiter controller.
//
// Handshake: reqN is raised with opN/aN/bN and held until ackN. The arbiter
// samples requests only while idle. ackN is a single-cycle pulse; res, cout and
// ovf are valid in that cycle and hold until the next capture. A requester
// that keeps reqN high after its ack is treated as presenting a new job.
interface addsub_arbiter_if #(parameter int W = 4);
  logic         req0;
  logic         op0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic         req1;
  logic         op1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         ack0;
  logic         ack1;
  logic [W-1:0] res;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic [W-1:0] opa_o;
  logic [W-1:0] opb_o;
  logic         cpl_o;
  logic         cin_o;
  logic [W-1:0] sum_i;
  logic         cout_i;

  // Controller side
  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1, sum_i, cout_i,
    output ack0, ack1, res, cout, ovf, busy, opa_o, opb_o, cpl_o, cin_o
  );

  // Requesters plus datapath side
  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1, sum_i, cout_i,
    input  ack0, ack1, res, cout, ovf, busy, opa_o, opb_o, cpl_o, cin_o
  );
endinterface

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin controller sharing one complementer + adder
// between two requesters. IDLE -> EXEC -> DONE -> IDLE, one op per 3 cycles.
// Optional macro ONES_COMPL_MODE_EN selects one's complement subtraction with
// an end-around-carry FIX pass; default build is two's complement.
module addsub_arbiter #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  addsub_arbiter_if.slave  bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } state_t;

`ifdef ONES_COMPL_MODE_EN
  localparam logic SUB_CIN = 1'b0;
`else
  localparam logic SUB_CIN = 1'b1;
`endif

  state_t       state;
  logic         rr;       // index of the requester served last
  logic         gnt;      // index of the requester currently granted
  logic         pick;
  logic [W-1:0] beff;
  logic         ovf_next;
`ifdef ONES_COMPL_MODE_EN
  logic         fp_a_msb; // first-pass sign bits, kept for the FIX overflow
  logic         fp_b_msb;
`endif

  assign dbg_state = state;
  assign beff      = bus.opb_o ^ {W{bus.cpl_o}};
  assign ovf_next  = (bus.opa_o[W-1] == beff[W-1]) &&
                     (bus.sum_i[W-1] != bus.opa_o[W-1]);

  // Winner selection: on contention favour the requester not served last
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ~rr;
    else if (bus.req1)        pick = 1'b1;
  end

  // Controller FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b1;
      gnt       <= 1'b0;
      bus.ack0  <= 1'b0;
      bus.ack1  <= 1'b0;
      bus.res   <= '0;
      bus.cout  <= 1'b0;
      bus.ovf   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.opa_o <= '0;
      bus.opb_o <= '0;
      bus.cpl_o <= 1'b0;
      bus.cin_o <= 1'b0;
`ifdef ONES_COMPL_MODE_EN
      fp_a_msb  <= 1'b0;
      fp_b_msb  <= 1'b0;
`endif
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt       <= pick;
            bus.opa_o <= pick ? bus.a1 : bus.a0;
            bus.opb_o <= pick ? bus.b1 : bus.b0;
            bus.cpl_o <= pick ? bus.op1 : bus.op0;
            bus.cin_o <= (pick ? bus.op1 : bus.op0) & SUB_CIN;
            bus.busy  <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rr       <= gnt;
          bus.cout <= bus.cout_i;
`ifdef ONES_COMPL_MODE_EN
          if (bus.cpl_o && bus.cout_i) begin
            // End-around carry: feed the first sum back with carry-in 1
            fp_a_msb  <= bus.opa_o[W-1];
            fp_b_msb  <= beff[W-1];
            bus.opa_o <= bus.sum_i;
            bus.opb_o <= '0;
            bus.cpl_o <= 1'b0;
            bus.cin_o <= 1'b1;
            bus.cout  <= 1'b1;
            state     <= FIX;
          end else begin
            bus.res  <= bus.sum_i;
            bus.ovf  <= ovf_next;
            bus.ack0 <= ~gnt;
            bus.ack1 <= gnt;
            state    <= DONE;
          end
`else
          bus.res  <= bus.sum_i;
          bus.ovf  <= ovf_next;
          bus.ack0 <= ~gnt;
          bus.ack1 <= gnt;
          state    <= DONE;
`endif
        end
`ifdef ONES_COMPL_MODE_EN
        FIX: begin
          bus.res  <= bus.sum_i;
          bus.ovf  <= (fp_a_msb == fp_b_msb) && (bus.sum_i[W-1] != fp_a_msb);
          bus.ack0 <= ~gnt;
          bus.ack1 <= gnt;
          state    <= DONE;
        end
`endif
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter; models the shared datapath and checks results
// against an arithmetic reference of add/sub modulo 16.
module tb_addsub_arbiter;
  localparam int W = 4;
`ifdef ONES_COMPL_MODE_EN
  localparam bit ONES_MODE = 1'b1;
`else
  localparam bit ONES_MODE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         last_served;
  logic [5:0] exp_q[$];   // {ovf, cout, res}

  addsub_arbiter_if #(.W(W)) bus();

  addsub_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // External datapath: complementer followed by the adder
  assign {bus.cout_i, bus.sum_i} = {1'b0, bus.opa_o} +
                                   {1'b0, bus.opb_o ^ {W{bus.cpl_o}}} +
                                   {4'b0000, bus.cin_o};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req0 = 0; bus.op0 = 0; bus.a0 = 0; bus.b0 = 0;
    bus.req1 = 0; bus.op1 = 0; bus.a1 = 0; bus.b1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic logic [5:0] ref_model(input logic op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r, u;
    logic c, o;
    logic [3:0] rs;
    ua = a; ub = b;
    if (!op) begin
      u  = ua + ub;
      c  = (u > 15);
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      r  = sa + sb;
      o  = (r > 7) || (r < -8);
    end else if (ONES_MODE) begin
      if (ua > ub) begin u = ua - ub; c = 1'b1; end
      else begin u = ua + 15 - ub; c = 1'b0; end
      sa = a[3] ? -(15 - ua) : ua;
      sb = b[3] ? -(15 - ub) : ub;
      r  = sa - sb;
      o  = (r > 7) || (r < -7);
    end else begin
      u  = ua - ub + 16;
      c  = (ua >= ub);
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      r  = sa - sb;
      o  = (r > 7) || (r < -8);
    end
    rs = u[3:0];
    return {o, c, rs};
  endfunction

  // Cycles from the request cycle to the ack cycle, inclusive
  function automatic int ref_cycles(input logic op, input logic [3:0] a, input logic [3:0] b);
    return (ONES_MODE && op && (a > b)) ? 4 : 3;
  endfunction

  // Driver: one requester performs one operation; checks latency and result
  task automatic do_op(input int idx, input logic op, input logic [3:0] a, input logic [3:0] b,
                       output logic cpl_x, output logic cin_x);
    int cyc;
    logic [5:0] exp;
    logic [1:0] exp_ack;
    @(negedge clk);
    exp_q.push_back(ref_model(op, a, b));
    if (idx == 0) begin bus.req0 = 1; bus.op0 = op; bus.a0 = a; bus.b0 = b; end
    else          begin bus.req1 = 1; bus.op1 = op; bus.a1 = a; bus.b1 = b; end
    cyc = 1; cpl_x = 0; cin_x = 0;
    while (!(bus.ack0 || bus.ack1) && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        cpl_x = bus.cpl_o; cin_x = bus.cin_o;
        // Operand changes after grant must not matter
        if (idx == 0) begin bus.op0 = 1'($urandom); bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); end
        else          begin bus.op1 = 1'($urandom); bus.a1 = 4'($urandom); bus.b1 = 4'($urandom); end
      end
    end
    exp = exp_q.pop_front();
    exp_ack = (idx == 0) ? 2'b01 : 2'b10;
    total_cnt++;
    if (cyc !== ref_cycles(op, a, b))
      $display("FAIL latency req%0d op=%0d %0d,%0d: got %0d cycles, expected %0d", idx, op, a, b, cyc, ref_cycles(op, a, b));
    else pass_cnt++;
    total_cnt++;
    if ({bus.ack1, bus.ack0} !== exp_ack)
      $display("FAIL ack_sel req%0d: got ack1ack0=%b, expected %b", idx, {bus.ack1, bus.ack0}, exp_ack);
    else pass_cnt++;
    total_cnt++;
    if ({bus.ovf, bus.cout, bus.res} !== exp)
      $display("FAIL result req%0d op=%0d a=%h b=%h: got ovf/cout/res=%b/%b/%h, expected %b/%b/%h",
               idx, op, a, b, bus.ovf, bus.cout, bus.res, exp[5], exp[4], exp[3:0]);
    else pass_cnt++;
    if (idx == 0) bus.req0 = 0; else bus.req1 = 0;
    last_served = idx;
    @(negedge clk);
    total_cnt++;
    if ({bus.ack1, bus.ack0, bus.busy} !== 3'b000)
      $display("FAIL post_ack req%0d: got ack1/ack0/busy=%b, expected 000", idx, {bus.ack1, bus.ack0, bus.busy});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    logic        stray;
    apply_reset();
    outs = {bus.ack0, bus.ack1, bus.res, bus.cout, bus.ovf, bus.busy,
            bus.opa_o, bus.opb_o, bus.cpl_o, bus.cin_o};
    total_cnt++;
    if (outs !== 19'd0 || dbg_state !== 2'd0)
      $display("FAIL reset_state: got outs=%h state=%0d, expected 0/0", outs, dbg_state);
    else pass_cnt++;
    // Abort an operation in flight
    @(negedge clk);
    bus.req1 = 1; bus.op1 = 1; bus.a1 = 4'h9; bus.b1 = 4'h6;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    outs = {bus.ack0, bus.ack1, bus.res, bus.cout, bus.ovf, bus.busy,
            bus.opa_o, bus.opb_o, bus.cpl_o, bus.cin_o};
    total_cnt++;
    if (outs !== 19'd0)
      $display("FAIL async_reset: got outs=%h, expected 0", outs);
    else pass_cnt++;
    bus.req1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      stray = stray | bus.ack0 | bus.ack1 | bus.busy;
    end
    total_cnt++;
    if (stray !== 1'b0)
      $display("FAIL reset_abort: got ack/busy activity=%b, expected 0", stray);
    else pass_cnt++;
  endtask

  // Both requesters hold req; winners must alternate, one ack per op
  task automatic test_contended(input int n_acks);
    logic       op_h[2];
    logic [3:0] a_h[2];
    logic [3:0] b_h[2];
    logic [5:0] exp;
    int cyc, winner;
    for (int i = 0; i < 2; i++) begin
      op_h[i] = 1'($urandom); a_h[i] = 4'($urandom); b_h[i] = 4'($urandom);
    end
    @(negedge clk);
    bus.req0 = 1; bus.op0 = op_h[0]; bus.a0 = a_h[0]; bus.b0 = b_h[0];
    bus.req1 = 1; bus.op1 = op_h[1]; bus.a1 = a_h[1]; bus.b1 = b_h[1];
    cyc = 1;
    for (int n = 0; n < n_acks; n++) begin
      while (!(bus.ack0 || bus.ack1) && cyc < 12) begin
        @(negedge clk);
        cyc++;
      end
      winner = 1 - last_served;
      exp = ref_model(op_h[winner], a_h[winner], b_h[winner]);
      total_cnt++;
      if ({bus.ack1, bus.ack0} !== ((winner == 0) ? 2'b01 : 2'b10))
        $display("FAIL rr_order ack %0d: got ack1ack0=%b, expected req%0d", n, {bus.ack1, bus.ack0}, winner);
      else pass_cnt++;
      total_cnt++;
      if (cyc !== ref_cycles(op_h[winner], a_h[winner], b_h[winner]))
        $display("FAIL rr_spacing ack %0d: got %0d cycles, expected %0d", n, cyc,
                 ref_cycles(op_h[winner], a_h[winner], b_h[winner]));
      else pass_cnt++;
      total_cnt++;
      if ({bus.ovf, bus.cout, bus.res} !== exp)
        $display("FAIL rr_result ack %0d: got %b/%b/%h, expected %b/%b/%h", n,
                 bus.ovf, bus.cout, bus.res, exp[5], exp[4], exp[3:0]);
      else pass_cnt++;
      last_served = winner;
      // The served requester keeps req high and presents its next job
      op_h[winner] = 1'($urandom); a_h[winner] = 4'($urandom); b_h[winner] = 4'($urandom);
      if (winner == 0) begin bus.op0 = op_h[0]; bus.a0 = a_h[0]; bus.b0 = b_h[0]; end
      else             begin bus.op1 = op_h[1]; bus.a1 = a_h[1]; bus.b1 = b_h[1]; end
      @(negedge clk);
      cyc = 1;
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_directed();
    logic cpl_x, cin_x;
    logic exp_cin;
    exp_cin = ONES_MODE ? 1'b0 : 1'b1;
    do_op(0, 1'b0, 4'd3, 4'd4, cpl_x, cin_x);
    total_cnt++;
    if ({bus.res, bus.cout, bus.ovf} !== {4'd7, 1'b0, 1'b0})
      $display("FAIL add_3_4: got res=%h cout=%b ovf=%b, expected 7/0/0", bus.res, bus.cout, bus.ovf);
    else pass_cnt++;
    do_op(1, 1'b1, 4'd5, 4'd7, cpl_x, cin_x);
    total_cnt++;
    if ({cpl_x, cin_x} !== {1'b1, exp_cin})
      $display("FAIL sub_ctrl: got cpl/cin=%b/%b, expected 1/%b", cpl_x, cin_x, exp_cin);
    else pass_cnt++;
    do_op(0, 1'b0, 4'd7, 4'd1, cpl_x, cin_x);
    total_cnt++;
    if ({bus.res, bus.ovf} !== {4'h8, 1'b1})
      $display("FAIL add_ovf: got res=%h ovf=%b, expected 8/1", bus.res, bus.ovf);
    else pass_cnt++;
    do_op(1, 1'b1, 4'h8, 4'd1, cpl_x, cin_x);
    total_cnt++;
    if ({bus.res, bus.cout, bus.ovf} !== {4'd7, 1'b1, 1'b1})
      $display("FAIL sub_ovf: got res=%h cout=%b ovf=%b, expected 7/1/1", bus.res, bus.cout, bus.ovf);
    else pass_cnt++;
    do_op(0, 1'b1, 4'd5, 4'd3, cpl_x, cin_x);
    do_op(0, 1'b1, 4'd3, 4'd5, cpl_x, cin_x);
    do_op(1, 1'b1, 4'd6, 4'd6, cpl_x, cin_x);
    do_op(0, 1'b0, 4'hF, 4'hF, cpl_x, cin_x);
  endtask

  task automatic test_random(input int n);
    logic cpl_x, cin_x;
    for (int i = 0; i < n; i++)
      do_op($urandom_range(0, 1), 1'($urandom), 4'($urandom), 4'($urandom), cpl_x, cin_x);
  endtask

  initial begin
    test_reset();
    test_contended(4);
    test_directed();
    test_random(30);
    test_contended(6);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
